// File: rtl/water_level_controller_pkg.sv
// Shared definitions for the water-box sequencing controller.
//   wb_rate_t   : 2-bit rate/direction code driven to the water-box group
//   demand_t    : irrigation demand codes
//   fsm_state_t : controller state encoding (3-bit)
//   *_DEF       : default thresholds / watchdog timeout
//   is_filling  : true in the states that add water and run the watchdog
package water_level_controller_pkg;

    typedef enum logic [1:0] {
        WB_FILL    = 2'b00,
        WB_DRAIN_G = 2'b01,
        WB_DRAIN_A = 2'b10,
        WB_DRAIN_E = 2'b11
    } wb_rate_t;

    typedef enum logic [1:0] {
        DEMAND_NONE      = 2'b00,
        DEMAND_DRIP      = 2'b01,
        DEMAND_SPRINKLER = 2'b10,
        DEMAND_SPRAY     = 2'b11
    } demand_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_IRRIGATE = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_FAULT    = 3'd4
    } fsm_state_t;

    localparam int unsigned LOW_TH_DEF       = 2;
    localparam int unsigned HIGH_TH_DEF      = 6;
    localparam int unsigned FILL_TIMEOUT_DEF = 16;

    function automatic logic is_filling(input fsm_state_t s);
        return (s == ST_FILL) || (s == ST_LOCKOUT);
    endfunction

endpackage

// File: rtl/water_level_controller_fill_watchdog.sv
// Fill watchdog: counts tick strobes while a fill makes no progress.
//   clock   in  system clock, rising edge
//   reset   in  synchronous, active-high
//   run     in  1 while the controller is filling (FILL or LOCKOUT)
//   clear   in  1 when the tank level moved this cycle
//   tick    in  1-cycle time-base strobe
//   expired out 1 once the count has reached FILL_TIMEOUT
module water_level_controller_fill_watchdog #(
    parameter int unsigned FILL_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned W     = $clog2(FILL_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(FILL_TIMEOUT);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] count;

    // Held at zero whenever not filling, so every fill entry starts from zero.
    // Clear beats a coincident tick; the count saturates at LIMIT.
    always_ff @(posedge clock) begin
        if (reset || !run || clear) begin
            count <= '0;
        end else if (tick && (count != LIMIT)) begin
            count <= count + ONE;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/water_level_controller.sv
// Sequencing FSM producing the rate/direction code for the water-box group.
// Tops the tank up with hysteresis, serves irrigation demand, locks out
// irrigation after run-dry, and faults when a fill stalls.
//   clock       in  system clock, rising edge
//   reset       in  synchronous, active-high
//   enable      in  0 parks the controller in IDLE (no effect in FAULT)
//   tick        in  watchdog time-base strobe
//   level       in  tank level 0..7
//   demand      in  00 none, 01 drip, 10 sprinkler, 11 spray
//   fault_ack   in  clears FAULT
//   state       out rate/direction code (registered)
//   hold        out water-box counter must freeze (registered)
//   fill_active out FILL or LOCKOUT (registered)
//   low_alarm   out LOCKOUT (registered)
//   fault       out FAULT (registered)
module water_level_controller
    import water_level_controller_pkg::*;
#(
    parameter int unsigned LOW_TH       = LOW_TH_DEF,
    parameter int unsigned HIGH_TH      = HIGH_TH_DEF,
    parameter int unsigned FILL_TIMEOUT = FILL_TIMEOUT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [2:0] level,
    input  logic [1:0] demand,
    input  logic       fault_ack,
    output logic [1:0] state,
    output logic       hold,
    output logic       fill_active,
    output logic       low_alarm,
    output logic       fault
);

    localparam logic [2:0] LOW_LVL  = 3'(LOW_TH);
    localparam logic [2:0] HIGH_LVL = 3'(HIGH_TH);

    fsm_state_t fsm;
    fsm_state_t next_fsm;
    logic [2:0] level_q;
    logic       wd_expired;

    always_ff @(posedge clock) begin
        level_q <= level;
    end

    water_level_controller_fill_watchdog #(
        .FILL_TIMEOUT(FILL_TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .run     (is_filling(fsm)),
        .clear   (level != level_q),
        .tick    (tick),
        .expired (wd_expired)
    );

    always_comb begin
        next_fsm = fsm;
        unique case (fsm)
            ST_IDLE: begin
                if (!enable) begin
                    next_fsm = ST_IDLE;
                end else if ((demand != DEMAND_NONE) && (level != 3'd0)) begin
                    next_fsm = ST_IRRIGATE;
                end else if (level <= LOW_LVL) begin
                    next_fsm = ST_FILL;
                end
            end
            // Completion is tested first so a full tank beats a coincident
            // watchdog expiry; level 7 is caught by the same compare.
            ST_FILL, ST_LOCKOUT: begin
                if (level >= HIGH_LVL) begin
                    next_fsm = ST_IDLE;
                end else if (!enable) begin
                    next_fsm = ST_IDLE;
                end else if (wd_expired) begin
                    next_fsm = ST_FAULT;
                end
            end
            ST_IRRIGATE: begin
                if (!enable || (demand == DEMAND_NONE)) begin
                    next_fsm = ST_IDLE;
                end else if (level == 3'd0) begin
                    next_fsm = ST_LOCKOUT;
                end
            end
            ST_FAULT: begin
                if (fault_ack) begin
                    next_fsm = ST_IDLE;
                end
            end
            default: next_fsm = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm         <= ST_IDLE;
            state       <= WB_FILL;
            hold        <= 1'b1;
            fill_active <= 1'b0;
            low_alarm   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            fsm         <= next_fsm;
            state       <= (next_fsm == ST_IRRIGATE) ? demand : WB_FILL;
            hold        <= (next_fsm == ST_IDLE) || (next_fsm == ST_FAULT);
            fill_active <= is_filling(next_fsm);
            low_alarm   <= (next_fsm == ST_LOCKOUT);
            fault       <= (next_fsm == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_water_level_controller.sv
// Self-checking bench for water_level_controller: directed scenarios followed
// by randomized stimulus, every cycle compared with a behavioural model.
module tb_water_level_controller;

    localparam int LOW_TH       = 2;
    localparam int HIGH_TH      = 6;
    localparam int FILL_TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [2:0] level;
    logic [1:0] demand;
    logic       fault_ack;
    logic [1:0] state;
    logic       hold;
    logic       fill_active;
    logic       low_alarm;
    logic       fault;

    always #5 clock = ~clock;

    water_level_controller #(
        .LOW_TH       (LOW_TH),
        .HIGH_TH      (HIGH_TH),
        .FILL_TIMEOUT (FILL_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .tick        (tick),
        .level       (level),
        .demand      (demand),
        .fault_ack   (fault_ack),
        .state       (state),
        .hold        (hold),
        .fill_active (fill_active),
        .low_alarm   (low_alarm),
        .fault       (fault)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode names, an integer stall timer and the last level.
    typedef enum int {M_IDLE, M_FILL, M_IRR, M_LOCK, M_FAULT} mode_t;
    mode_t m_mode  = M_IDLE;
    int    m_code  = 0;
    int    m_stall = 0;
    int    m_prev  = 0;

    function automatic logic [5:0] expected_outs();
        logic [1:0] code;
        logic       h;
        code = (m_mode == M_IRR) ? 2'(m_code) : 2'b00;
        h    = (m_mode == M_IDLE) || (m_mode == M_FAULT);
        return {code, h, (m_mode == M_FILL) || (m_mode == M_LOCK),
                m_mode == M_LOCK, m_mode == M_FAULT};
    endfunction

    function automatic logic [5:0] dut_outs();
        return {state, hold, fill_active, low_alarm, fault};
    endfunction

    // Applies the controller rules to the inputs present at a rising edge.
    task automatic model_edge();
        int    lv;
        int    dm;
        mode_t nxt;
        bit    filling;
        lv = int'(level);
        dm = int'(demand);
        if (reset) begin
            m_mode  = M_IDLE;
            m_stall = 0;
        end else begin
            filling = (m_mode == M_FILL) || (m_mode == M_LOCK);
            nxt = m_mode;
            case (m_mode)
                M_IDLE:
                    if (enable) begin
                        if (dm != 0 && lv > 0) nxt = M_IRR;
                        else if (lv <= LOW_TH) nxt = M_FILL;
                    end
                M_FILL, M_LOCK:
                    if (lv >= HIGH_TH || !enable) nxt = M_IDLE;
                    else if (m_stall == FILL_TIMEOUT) nxt = M_FAULT;
                M_IRR:
                    if (!enable || dm == 0) nxt = M_IDLE;
                    else if (lv == 0) nxt = M_LOCK;
                M_FAULT:
                    if (fault_ack) nxt = M_IDLE;
                default: nxt = M_IDLE;
            endcase
            if (!filling || lv != m_prev) m_stall = 0;
            else if (tick && m_stall < FILL_TIMEOUT) m_stall++;
            if (nxt == M_IRR) m_code = dm;
            m_mode = nxt;
        end
        m_prev = lv;
    endtask

    // One clock: drive on the falling edge, model at the rising edge,
    // compare 1 time unit later.
    task automatic step(input string tag, input logic rst, input logic en,
                        input logic tk, input logic [2:0] lv,
                        input logic [1:0] dm, input logic ack);
        @(negedge clock);
        reset     = rst;
        enable    = en;
        tick      = tk;
        level     = lv;
        demand    = dm;
        fault_ack = ack;
        @(posedge clock);
        model_edge();
        #1;
        check_eq(tag, 32'(dut_outs()), 32'(expected_outs()));
    endtask

    initial begin
        logic [2:0] lv;
        logic [1:0] dm;
        logic       en;
        int         chg_rate;

        reset = 1'b1; enable = 1'b0; tick = 1'b0; level = 3'd4;
        demand = 2'b00; fault_ack = 1'b0;

        // 1: reset, then release with no demand.
        step("reset0", 1, 0, 0, 3'd4, 2'b00, 0);
        step("reset1", 1, 0, 0, 3'd4, 2'b00, 0);
        check_eq("reset_outs", 32'(dut_outs()), 32'(6'b00_1_0_0_0));
        step("idle_rel", 0, 1, 0, 3'd4, 2'b00, 0);
        step("idle_stay", 0, 1, 0, 3'd4, 2'b00, 0);
        check_eq("idle_hold", 32'(hold), 32'(1));

        // 2: top-up fill and hysteresis.
        step("fill_go", 0, 1, 0, 3'd2, 2'b00, 0);
        check_eq("fill_outs", 32'(dut_outs()), 32'(6'b00_0_1_0_0));
        for (int i = 3; i <= 6; i++) step("fill_ramp", 0, 1, 1, 3'(i), 2'b10, 0);
        check_eq("fill_done", 32'(dut_outs()), 32'(6'b00_1_0_0_0));

        // 3: irrigation follows demand.
        step("irr_go", 0, 1, 0, 3'd5, 2'b10, 0);
        check_eq("irr_code10", 32'(state), 32'(2'b10));
        step("irr_track", 0, 1, 0, 3'd5, 2'b11, 0);
        check_eq("irr_code11", 32'(state), 32'(2'b11));
        step("irr_stop", 0, 1, 0, 3'd5, 2'b00, 0);

        // 4: run dry into lockout, refill, then serve the pending demand.
        step("irr_go2", 0, 1, 0, 3'd5, 2'b01, 0);
        for (int i = 4; i >= 0; i--) step("irr_drain", 0, 1, 0, 3'(i), 2'b01, 0);
        check_eq("lockout_outs", 32'(dut_outs()), 32'(6'b00_0_1_1_0));
        for (int i = 1; i <= 6; i++) step("lock_fill", 0, 1, 0, 3'(i), 2'b01, 0);
        step("lock_reirr", 0, 1, 0, 3'd6, 2'b01, 0);
        check_eq("reirr_code", 32'(state), 32'(2'b01));

        // 5: stalled fill faults; enable has no effect; ack clears.
        step("to_idle", 0, 1, 0, 3'd1, 2'b00, 0);
        step("fill_stall", 0, 1, 0, 3'd1, 2'b00, 0);
        for (int i = 0; i < FILL_TIMEOUT; i++) begin
            step("stall_tick", 0, 1, 1, 3'd1, 2'b00, 0);
            step("stall_gap", 0, 1, 0, 3'd1, 2'b00, 0);
        end
        step("stall_trip", 0, 1, 0, 3'd1, 2'b00, 0);
        check_eq("fault_outs", 32'(dut_outs()), 32'(6'b00_1_0_0_1));
        step("fault_en0", 0, 0, 0, 3'd1, 2'b00, 0);
        step("fault_en1", 0, 1, 0, 3'd1, 2'b01, 0);
        check_eq("fault_kept", 32'(fault), 32'(1));
        step("fault_ack", 0, 1, 0, 3'd1, 2'b00, 1);
        check_eq("ack_idle", 32'(dut_outs()), 32'(6'b00_1_0_0_0));

        // 6: level change on the 15th tick restarts the watchdog.
        step("fill_again", 0, 1, 0, 3'd1, 2'b00, 0);
        for (int i = 0; i < 15; i++)
            step("wd_tick", 0, 1, 1, (i == 14) ? 3'd2 : 3'd1, 2'b00, 0);
        for (int i = 0; i < FILL_TIMEOUT - 1; i++)
            step("wd_retick", 0, 1, 1, 3'd2, 2'b00, 0);
        step("wd_noflt", 0, 1, 0, 3'd2, 2'b00, 0);
        check_eq("wd_cleared", 32'(dut_outs()), 32'(6'b00_0_1_0_0));
        step("mid_reset", 1, 1, 1, 3'd2, 2'b00, 0);
        check_eq("mid_reset_outs", 32'(dut_outs()), 32'(6'b00_1_0_0_0));

        // Randomized phase: slow-moving level so both completion and stalls occur.
        lv = 3'd3; dm = 2'b00;
        chg_rate = 2;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) chg_rate = ($urandom_range(0, 1) == 0) ? 2 : 40;
            if ($urandom_range(0, chg_rate - 1) == 0) begin
                if ((m_mode == M_FILL || m_mode == M_LOCK) ? ($urandom_range(0, 9) < 7)
                                                           : ($urandom_range(0, 1) == 0))
                    lv = (lv == 3'd7) ? lv : lv + 3'd1;
                else
                    lv = (lv == 3'd0) ? lv : lv - 3'd1;
            end
            if ($urandom_range(0, 7) == 0) dm = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 15) != 0);
            step("rand", ($urandom_range(0, 199) == 0), en,
                 ($urandom_range(0, 2) == 0), lv, dm,
                 ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
